// File: rtl/valid_wr_ctrl_pkg.sv
// Shared constants and FSM encoding for the cache valid-table write controller.
package valid_wr_ctrl_pkg;

  localparam int CACHE_INDEX_W = 8;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

endpackage

// File: rtl/valid_wr_ctrl.sv
// Sweeps the valid table to 0 after reset and on flush; otherwise arbitrates
// set / invalidate / lookup onto the table's single shared index.
module valid_wr_ctrl
  import valid_wr_ctrl_pkg::*;
#(
  parameter int INDEX_W = CACHE_INDEX_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_req_i,
  output logic               flush_done_o,
  input  logic               set_req_i,
  input  logic [INDEX_W-1:0] set_index_i,
  output logic               set_ack_o,
  input  logic               inv_req_i,
  input  logic [INDEX_W-1:0] inv_index_i,
  output logic               inv_ack_o,
  input  logic               lookup_req_i,
  input  logic [INDEX_W-1:0] lookup_index_i,
  output logic               lookup_ack_o,
  output logic               lookup_vld_o,
  output logic               busy_o,
  output logic [INDEX_W-1:0] index_o,
  output logic               wr_en_o,
  output logic               wr_valid_o
);

  state_e             r_state, w_state_nxt;
  logic [INDEX_W-1:0] r_cnt, w_cnt_nxt;
  logic               r_done_pend, w_done_pend_nxt;
  logic               r_flush_done, w_flush_done_nxt;
  logic               r_lookup_vld;

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_done_pend_nxt  = r_done_pend;
    w_flush_done_nxt = 1'b0;
    index_o          = lookup_index_i;
    wr_en_o          = 1'b0;
    wr_valid_o       = 1'b0;
    set_ack_o        = 1'b0;
    inv_ack_o        = 1'b0;
    lookup_ack_o     = 1'b0;
    busy_o           = 1'b0;
    if (rst) begin
      busy_o          = 1'b1;
      index_o         = '0;
      w_state_nxt     = ST_INIT;
      w_cnt_nxt       = '0;
      w_done_pend_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_INIT, ST_FLUSH: begin
          wr_en_o   = 1'b1;
          index_o   = r_cnt;
          busy_o    = 1'b1;
          w_cnt_nxt = r_cnt + INDEX_W'(1);
          // A flush arriving mid-sweep rides along with this sweep.
          if (flush_req_i) w_done_pend_nxt = 1'b1;
          if (&r_cnt) begin
            w_state_nxt      = ST_IDLE;
            w_flush_done_nxt = r_done_pend | flush_req_i;
            w_done_pend_nxt  = 1'b0;
          end
        end
        ST_IDLE: begin
          if (flush_req_i) begin
            w_state_nxt     = ST_FLUSH;
            w_cnt_nxt       = '0;
            w_done_pend_nxt = 1'b1;
          end else if (set_req_i) begin
            wr_en_o    = 1'b1;
            wr_valid_o = 1'b1;
            index_o    = set_index_i;
            set_ack_o  = 1'b1;
          end else if (inv_req_i) begin
            wr_en_o   = 1'b1;
            index_o   = inv_index_i;
            inv_ack_o = 1'b1;
          end else if (lookup_req_i) begin
            lookup_ack_o = 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_INIT;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_INIT;
      r_cnt        <= '0;
      r_done_pend  <= 1'b0;
      r_flush_done <= 1'b0;
      r_lookup_vld <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_done_pend  <= w_done_pend_nxt;
      r_flush_done <= w_flush_done_nxt;
      r_lookup_vld <= lookup_ack_o;
    end
  end

  assign flush_done_o = r_flush_done;
  assign lookup_vld_o = r_lookup_vld;

endmodule

// File: tb/tb_valid_wr_ctrl.sv
// Directed + random bench for valid_wr_ctrl with a behavioural table and a
// sweep-count / valid-bit reference model.
module tb_valid_wr_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush_req_i = 1'b0, set_req_i = 1'b0, inv_req_i = 1'b0, lookup_req_i = 1'b0;
  logic [7:0] set_index_i = '0, inv_index_i = '0, lookup_index_i = '0;
  logic       flush_done_o, set_ack_o, inv_ack_o, lookup_ack_o, lookup_vld_o;
  logic       busy_o, wr_en_o, wr_valid_o;
  logic [7:0] index_o;

  valid_wr_ctrl #(.INDEX_W(8)) dut (
    .clk(clk), .rst(rst),
    .flush_req_i(flush_req_i), .flush_done_o(flush_done_o),
    .set_req_i(set_req_i), .set_index_i(set_index_i), .set_ack_o(set_ack_o),
    .inv_req_i(inv_req_i), .inv_index_i(inv_index_i), .inv_ack_o(inv_ack_o),
    .lookup_req_i(lookup_req_i), .lookup_index_i(lookup_index_i),
    .lookup_ack_o(lookup_ack_o), .lookup_vld_o(lookup_vld_o),
    .busy_o(busy_o), .index_o(index_o), .wr_en_o(wr_en_o), .wr_valid_o(wr_valid_o)
  );

  always #5 clk = ~clk;

  // Stand-in valid table: write-first, registered read on the shared index.
  logic mem [256];
  logic tbl_rd;
  always @(posedge clk) begin
    if (wr_en_o) begin
      mem[index_o] <= wr_valid_o;
      tbl_rd       <= wr_valid_o;
    end else begin
      tbl_rd <= mem[index_o];
    end
  end

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: writes left in the current sweep, owed done pulse,
  // expected registered outputs, and the expected contents of the table.
  int       m_left   = 0;
  bit       m_owed   = 0;
  bit       m_done   = 0;
  bit       m_lvld   = 0;
  bit [7:0] m_lidx   = 0;
  bit       exp_valid [256];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive inputs, check combinational outputs, step the model on
  // the edge, then check registered outputs and the table read.
  task automatic step(input bit r, input bit f, input bit s, input bit [7:0] si,
                      input bit iv, input bit [7:0] ii, input bit l, input bit [7:0] li);
    bit [7:0] sw_idx;
    rst = r; flush_req_i = f; set_req_i = s; set_index_i = si;
    inv_req_i = iv; inv_index_i = ii; lookup_req_i = l; lookup_index_i = li;
    #1;
    sw_idx = 8'(256 - m_left);
    if (r) begin
      chk("rst_busy", busy_o, 1); chk("rst_wr_en", wr_en_o, 0);
      chk("rst_index", index_o, 0); chk("rst_wr_valid", wr_valid_o, 0);
      chk("rst_acks", {set_ack_o, inv_ack_o, lookup_ack_o}, 0);
    end else if (m_left > 0) begin
      chk("sw_busy", busy_o, 1); chk("sw_wr_en", wr_en_o, 1);
      chk("sw_index", index_o, sw_idx); chk("sw_wr_valid", wr_valid_o, 0);
      chk("sw_acks", {set_ack_o, inv_ack_o, lookup_ack_o}, 0);
    end else begin
      chk("idle_busy", busy_o, 0);
      chk("idle_wr_en", wr_en_o, !f && (s || iv));
      chk("idle_acks", {set_ack_o, inv_ack_o, lookup_ack_o},
          {!f && s, !f && !s && iv, !f && !s && !iv && l});
      if (!f) chk("idle_index", index_o, s ? si : iv ? ii : li);
      if (!f && (s || iv)) chk("idle_wr_valid", wr_valid_o, s);
    end
    @(posedge clk);
    if (r) begin
      m_left = 256; m_owed = 0; m_done = 0; m_lvld = 0;
    end else if (m_left > 0) begin
      exp_valid[sw_idx] = 0;
      m_owed = m_owed | f;
      m_left--;
      m_done = (m_left == 0) && m_owed;
      if (m_left == 0) m_owed = 0;
      m_lvld = 0;
    end else begin
      m_done = 0; m_lvld = 0;
      if (f) begin m_left = 256; m_owed = 1; end
      else if (s) exp_valid[si] = 1;
      else if (iv) exp_valid[ii] = 0;
      else if (l) begin m_lvld = 1; m_lidx = li; end
    end
    @(negedge clk);
    chk("lookup_vld", lookup_vld_o, m_lvld);
    chk("flush_done", flush_done_o, m_done);
    if (m_lvld) chk("rd_valid", tbl_rd, exp_valid[m_lidx]);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    @(negedge clk);
    // Reset for 3 cycles, then the full INIT sweep with no done pulse.
    for (int k = 0; k < 3; k++) step(1, 0, 0, 0, 0, 0, 0, 0);
    idle(260);

    // Set then look up the same line and its neighbour.
    step(0, 0, 1, 8'h3A, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 8'h3A);
    step(0, 0, 0, 0, 0, 0, 1, 8'h3B);
    idle(2);

    // Set and inv collide: set first, inv held to the next cycle.
    step(0, 0, 1, 8'h10, 1, 8'h20, 0, 0);
    step(0, 0, 0, 0, 1, 8'h20, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 8'h10);
    step(0, 0, 0, 0, 0, 0, 1, 8'h20);

    // Same-index writes back to back; last one wins.
    step(0, 0, 1, 8'h44, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 8'h44, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 8'h44);

    // Flush clears previously set lines.
    step(0, 0, 1, 8'h05, 0, 0, 0, 0);
    step(0, 0, 1, 8'hFF, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    idle(258);
    step(0, 0, 0, 0, 0, 0, 1, 8'h05);
    step(0, 0, 0, 0, 0, 0, 1, 8'hFF);
    idle(1);

    // Flush request during INIT is absorbed; one done pulse at the end.
    step(1, 0, 0, 0, 0, 0, 0, 0);
    idle(100);
    step(0, 1, 1, 8'h01, 1, 8'h02, 1, 8'h03);
    idle(160);

    // Reset in the middle of a flush sweep drops the pending done.
    step(0, 1, 0, 0, 0, 0, 0, 0);
    idle(50);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    idle(260);

    // Random traffic over a narrow index range so lookups hit written lines.
    for (int k = 0; k < 900; k++) begin
      bit [7:0] a, b, c;
      a = 8'($urandom_range(0, 15)); b = 8'($urandom_range(0, 15)); c = 8'($urandom_range(0, 15));
      if (($urandom % 8) == 0) begin a[7] = 1'b1; c[7] = 1'b1; end
      step(($urandom % 400) == 0, ($urandom % 120) == 0,
           ($urandom % 4) == 0, a, ($urandom % 4) == 0, b, ($urandom % 2) == 0, c);
    end
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
